pipeline_fetch_unit: RTL
========================

Name: pipeline_fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the single-register PC/IF stage of the 5-stage MIPS pipeline. It issues requests to a variable-latency instruction memory through a req/gnt + rvalid interface, and buffers fetched {pc, instr} pairs in a FQ_DEPTH-entry prefetch queue. It presents them to ID with a valid/ready handshake. Branch, jump, jr and interrupt redirects flush the queue and discard in-flight responses.

Parameters:
XLEN, 32, width of PC and instruction word
FQ_DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_VEC, 32'h80000000, first fetch address after reset
INT_VEC, 32'h80000004, redirect target on irq

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in order
imem_rdata  in  XLEN  instruction word
redirect_valid  in  1  branch/jump/jr redirect from EX/ID
redirect_pc  in  XLEN  redirect target
irq  in  1  interrupt redirect request
id_valid  out  1  queue head valid toward ID
id_ready  in  1  ID accepts head (IF/ID write enable)
id_instr  out  XLEN  head instruction
id_pc  out  XLEN  head PC
id_next_pc  out  XLEN  head PC + 4

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_VEC, queue empty, outstanding=0, discard=0. Outputs: imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_next_pc=4. imem_addr shows fetch_pc.
- Max one outstanding memory request.
- imem_req=1 when: not redirecting this cycle; (outstanding=0 or imem_rvalid=1 this cycle); and registered count + outstanding < FQ_DEPTH. Credit check uses registered values only; no lookahead on a same-cycle pop.
- imem_addr = fetch_pc. On imem_req && imem_gnt: fetch_pc <= fetch_pc + 4 (mod 2^XLEN, so 0xFFFFFFFC wraps to 0), req_pc <= fetch_pc, outstanding <= 1.
- On imem_rvalid: outstanding <= 0 unless re-granted the same cycle.
  - If discard=1: the response is dropped and discard <= 0.
  - Otherwise {req_pc, imem_rdata} is pushed at the tail.
- imem_rvalid with outstanding=0 is ignored.
- Queue: circular buffer with read/write pointers and count of log2(FQ_DEPTH)+1 bits.
  - Push and pop in the same cycle are legal at any fill level, including full; count is unchanged.
  - Head fields are driven combinationally from the read pointer.
  - Minimum latency from rvalid to id_valid: 1 cycle.
  - Sustained throughput: 1 instr/cycle when memory latency is 1 and gnt=1.
- id_valid = (count != 0) && !irq && !redirect_valid. Pop occurs on id_valid && id_ready.
- Redirect cycle (irq or redirect_valid):
  - Target is INT_VEC if irq=1, else redirect_pc with bits [1:0] forced to 0. irq wins over a simultaneous redirect.
  - The queue is flushed (count=0, pointers reset). Any pop or push in that cycle has no effect.
  - fetch_pc <= target. imem_req=0 this cycle.
  - If outstanding=1 and imem_rvalid=0: discard <= 1. If imem_rvalid=1 this cycle, the response is dropped and discard stays 0.
  - The first request to the target is issued in the next cycle.
- Back-to-back redirects: the last one wins and each flushes again.
- Reset asserted mid-operation: state returns to reset values immediately. The memory side must also be reset; a response arriving after reset is ignored because outstanding=0.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetch_cnt (out, 32) and perf_stall_cnt (out, 32), both reset to 0.
- perf_fetch_cnt increments on each pop.
- perf_stall_cnt increments on each cycle with id_ready=1 && id_valid=0 && no redirect.
- Both counters wrap at 2^32.
When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, 1-cycle memory, gnt=1, id_ready=1 -> imem_addr 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; id_pc follows in order at 1/cycle with id_next_pc=id_pc+4.
- id_ready=0, FQ_DEPTH=4 -> exactly 4 grants, then imem_req=0; set id_ready=1 -> 4 instructions in PC order, then fetching resumes at PC+16.
- 3-cycle memory latency, redirect_valid with redirect_pc=0x00000102 while a request is outstanding -> late response dropped, next imem_addr=0x00000100, first id_pc=0x00000100.
- irq and redirect_valid (0x00000400) in the same cycle with a full queue -> queue flushed, id_valid=0 that cycle, next imem_addr=0x80000004.
- redirect_pc=0xFFFFFFFC -> fetches at 0xFFFFFFFC then 0x00000000; id_next_pc=0x00000000 for the first instruction.
- reset driven low between clock edges mid-stream -> id_valid and imem_req drop to 0 immediately; after release, first imem_addr=0x80000000.

Source files
------------

// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit
//   Instruction-fetch front end for the 5-stage MIPS pipeline. Issues word fetches
//   to a variable-latency instruction memory (req/gnt + in-order rvalid), buffers
//   {pc, instr} pairs in a FQ_DEPTH-entry prefetch queue and hands the head to ID
//   over a valid/ready handshake. Branch/jump/jr redirects and irq flush the queue
//   and discard a response still in flight.
//
//   Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
//
//   Ports:
//     clk, reset             clock (rising edge), async active-low reset
//     imem_req/addr          fetch request and word-aligned address
//     imem_gnt               request accepted this cycle
//     imem_rvalid/rdata      in-order response
//     redirect_valid/pc      branch/jump/jr redirect
//     irq                    interrupt redirect to INT_VEC (wins over redirect)
//     id_valid/ready         head handshake toward ID
//     id_instr/pc/next_pc    head instruction, its PC and PC + 4
module pipeline_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     FQ_DEPTH  = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [XLEN-1:0] INT_VEC   = 32'h8000_0004
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            irq,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_next_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [XLEN-1:0] pc_mem_q    [FQ_DEPTH];
  logic [XLEN-1:0] instr_mem_q [FQ_DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            rsp_valid;
  logic [CntW:0]   inflight;
  logic            credit_ok;
  logic            grant;
  logic            push;
  logic            pop;

  always_comb begin
    redirect  = irq | redirect_valid;
    target    = irq ? INT_VEC : {redirect_pc[XLEN-1:2], 2'b00};
    // A response with nothing outstanding is stray and ignored.
    rsp_valid = imem_rvalid & outstanding_q;
    // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
    inflight  = {1'b0, count_q} + {{CntW{1'b0}}, outstanding_q};
    credit_ok = inflight < (CntW + 1)'(FQ_DEPTH);
    imem_req  = reset & ~redirect & (~outstanding_q | imem_rvalid) & credit_ok;
    imem_addr = fetch_pc_q;
    grant     = imem_req & imem_gnt;
    push      = rsp_valid & ~discard_q & ~redirect;
    id_valid  = (count_q != '0) & ~redirect;
    pop       = id_valid & id_ready;
    id_pc     = pc_mem_q[rptr_q];
    id_instr  = instr_mem_q[rptr_q];
    id_next_pc = id_pc + XLEN'(4);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    count_d       = count_q;

    if (grant) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
      req_pc_d      = fetch_pc_q;
      outstanding_d = 1'b1;
    end else if (rsp_valid) begin
      outstanding_d = 1'b0;
    end

    if (redirect) begin
      fetch_pc_d = target;
      // The pending response is still owed; mark it to be dropped on arrival.
      // If it arrives this very cycle it is simply dropped here.
      discard_d  = outstanding_q & ~imem_rvalid;
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
    end else begin
      if (rsp_valid && discard_q) begin
        discard_d = 1'b0;
      end
      if (push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_VEC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is reset so the head reads as zero while the queue is empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wptr_q]    <= req_pc_q;
      instr_mem_q[wptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (pop) begin
      perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
    end
    if (id_ready && !id_valid && !redirect) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
